// File: rtl/d_mem_responder_if.sv
// d_mem_responder_if: the core-side control signals and the loader port,
// plus the status outputs, for the data-memory responder.
// The 64-bit shared data bus is a plain inout on the responder rather than
// an interface member. This keeps the tristate resolution between the core
// and the memory on an ordinary net.
interface d_mem_responder_if #(
  parameter int d_addr_bits = 6
);
  logic                   d_mem_we;
  logic [d_addr_bits-1:0] d_mem_addr;
  logic                   ld_en;
  logic [d_addr_bits-1:0] ld_addr;
  logic [63:0]            ld_data;
  logic                   ready;
  logic                   conflict;
  logic [15:0]            wr_count;

  // Core/loader side: drives requests and observes status.
  modport master (
    output d_mem_we, d_mem_addr, ld_en, ld_addr, ld_data,
    input  ready, conflict, wr_count
  );

  // Memory side: accepts requests and reports status.
  modport slave (
    input  d_mem_we, d_mem_addr, ld_en, ld_addr, ld_data,
    output ready, conflict, wr_count
  );
endinterface

// File: rtl/d_mem_responder.sv
// d_mem_responder: memory-side responder for the core's data-memory port.
// - Holds 2^d_addr_bits 64-bit words.
// - Reads are combinational onto the shared bus. Writes are registered.
// - After reset, an init state machine clears every word and then raises
//   ready. The clear takes one word per clock.
// - The loader port can preload words. When the loader and the core write
//   in the same cycle, the loader wins and the sticky conflict flag is set.
// - Optional macro D_MEM_WR_COUNT_EN enables a saturating 16-bit counter of
//   accepted core writes. When the macro is undefined, wr_count is
//   constant zero.
module d_mem_responder #(
  parameter int d_addr_bits = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  d_mem_responder_if.slave bus,
  inout  wire  [63:0]  d_mem_data
);

  localparam int depth = 1 << d_addr_bits;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                 state_reg, state_next;
  logic [d_addr_bits-1:0] clr_cnt_reg, clr_cnt_next;
  logic                   conflict_reg, conflict_next;

  logic                   wr_en;
  logic [d_addr_bits-1:0] wr_addr;
  logic [63:0]            wr_data;
  logic                   core_wr;

  logic [63:0] mem [0:depth-1];

  // Next-state logic and selection of the single write port:
  // the init clear, then the loader, then the core.
  always_comb begin
    state_next    = state_reg;
    clr_cnt_next  = clr_cnt_reg;
    conflict_next = conflict_reg;
    wr_en         = 1'b0;
    wr_addr       = clr_cnt_reg;
    wr_data       = 64'h0;
    core_wr       = 1'b0;
    case (state_reg)
      ST_INIT: begin
        // Core and loader requests are ignored while clearing.
        wr_en        = 1'b1;
        clr_cnt_next = clr_cnt_reg + 1'b1;
        if (clr_cnt_reg == {d_addr_bits{1'b1}}) begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        if (bus.ld_en) begin
          wr_en   = 1'b1;
          wr_addr = bus.ld_addr;
          wr_data = bus.ld_data;
          if (bus.d_mem_we) begin
            conflict_next = 1'b1;
          end
        end else if (bus.d_mem_we) begin
          wr_en   = 1'b1;
          wr_addr = bus.d_mem_addr;
          wr_data = d_mem_data;
          core_wr = 1'b1;
        end
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  // Control registers. Reset returns to the clear phase from any state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_INIT;
      clr_cnt_reg  <= '0;
      conflict_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      clr_cnt_reg  <= clr_cnt_next;
      conflict_reg <= conflict_next;
    end
  end

  // Storage array. Contents are left untouched on a reset edge.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Drive the bus only when ready and the core is not driving it.
  assign d_mem_data = (state_reg == ST_READY && !bus.d_mem_we) ?
                      mem[bus.d_mem_addr] : {64{1'bz}};

  assign bus.ready    = (state_reg == ST_READY);
  assign bus.conflict = conflict_reg;

`ifdef D_MEM_WR_COUNT_EN
  logic [15:0] wr_count_reg;

  // Count accepted core writes, holding at the top value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_count_reg <= 16'h0000;
    end else if (core_wr && wr_count_reg != 16'hFFFF) begin
      wr_count_reg <= wr_count_reg + 16'h0001;
    end
  end

  assign bus.wr_count = wr_count_reg;
`else
  logic unused_core_wr;
  assign unused_core_wr = core_wr;
  assign bus.wr_count   = 16'h0000;
`endif

endmodule

// File: tb/tb_d_mem_responder.sv
// tb_d_mem_responder: self-checking bench for d_mem_responder.
// The bench pushes bus expectations to a scoreboard queue as it drives
// stimulus, and pops and compares them when the output is sampled.
// Status outputs are compared directly.
module tb_d_mem_responder;

  localparam int aw = 6;

`ifdef D_MEM_WR_COUNT_EN
  localparam bit cnt_en = 1'b1;
`else
  localparam bit cnt_en = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        core_drive;
  logic [63:0] core_data;
  wire  [63:0] d_mem_data;

  int checks   = 0;
  int failures = 0;
  int accepted_writes = 0;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];

  d_mem_responder_if #(.d_addr_bits(aw)) mif();

  d_mem_responder #(.d_addr_bits(aw)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (mif.slave),
    .d_mem_data (d_mem_data)
  );

  assign d_mem_data = core_drive ? core_data : {64{1'bz}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  function automatic logic [63:0] exp_count();
    return cnt_en ? 64'(accepted_writes) : 64'h0;
  endfunction

  // Advance one clock, then move just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push the expected bus value, let the bus settle, then pop and compare.
  task automatic sb_bus(input string tag, input logic [63:0] exp);
    sb_item_t it;
    sb_q.push_back('{tag, exp});
    #2;
    it = sb_q.pop_front();
    check_value(it.tag, d_mem_data, it.exp);
  endtask

  task automatic read_check(input string tag, input logic [aw-1:0] addr, input logic [63:0] exp);
    core_drive   = 1'b0;
    mif.d_mem_we = 1'b0;
    mif.d_mem_addr = addr;
    sb_bus(tag, exp);
  endtask

  task automatic idle_bus();
    core_drive     = 1'b0;
    mif.d_mem_we   = 1'b0;
    mif.ld_en      = 1'b0;
  endtask

  // Release reset and walk through the clear phase. Ready must stay low
  // for 63 edges and rise on the 64th.
  task automatic run_init(input bool_poke, input logic [63:0] stale63);
    rst_n = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (bool_poke && i == 10) begin
        // Core and loader both try to write address 7 during the clear.
        mif.d_mem_we = 1'b1; mif.d_mem_addr = 6'd7;
        core_drive = 1'b1; core_data = 64'hFF;
        mif.ld_en = 1'b1; mif.ld_addr = 6'd7; mif.ld_data = 64'hFF;
      end
      if (bool_poke && i == 13) idle_bus();
      if (!bool_poke && i == 2) begin
        mif.d_mem_we = 1'b0; mif.d_mem_addr = 6'd63;
      end
      if (!bool_poke && i == 3) begin
        // The word at 63 still holds old data, but the memory must not drive it.
        check_value("init_no_drive", {63'h0, (d_mem_data === stale63)}, 64'h0);
      end
      if (i == 63) check_value("init_ready_low_63", {63'h0, mif.ready}, 64'h0);
    end
    check_value("init_ready_high_64", {63'h0, mif.ready}, 64'h1);
  endtask

  initial begin
    rst_n = 1'b0;
    core_drive = 1'b0; core_data = 64'h0;
    mif.d_mem_we = 1'b0; mif.d_mem_addr = '0;
    mif.ld_en = 1'b0; mif.ld_addr = '0; mif.ld_data = 64'h0;

    // Reset held for three edges.
    repeat (3) step();
    check_value("rst_ready", {63'h0, mif.ready}, 64'h0);
    check_value("rst_conflict", {63'h0, mif.conflict}, 64'h0);
    check_value("rst_wr_count", {48'h0, mif.wr_count}, 64'h0);

    // Clear phase with write attempts to address 7 mixed in.
    run_init(1'b1, 64'h0);
    check_value("init_conflict", {63'h0, mif.conflict}, 64'h0);
    check_value("init_wr_count", {48'h0, mif.wr_count}, 64'h0);
    read_check("rd_addr0", 6'd0, 64'h0);
    read_check("rd_addr31", 6'd31, 64'h0);
    read_check("rd_addr63", 6'd63, 64'h0);
    read_check("rd_addr7_after_init_writes", 6'd7, 64'h0);

    // Loader write, then a same-cycle read.
    mif.ld_en = 1'b1; mif.ld_addr = 6'd5; mif.ld_data = 64'hDEAD_BEEF_0123_4567;
    step();
    mif.ld_en = 1'b0;
    read_check("ld_rd_addr5", 6'd5, 64'hDEAD_BEEF_0123_4567);

    // Core write to address 10. The bus must carry only the core's value.
    mif.d_mem_we = 1'b1; mif.d_mem_addr = 6'd10;
    core_drive = 1'b1; core_data = 64'hA5A5_A5A5_A5A5_A5A5;
    sb_bus("wr_bus_core_only", 64'hA5A5_A5A5_A5A5_A5A5);
    step();
    accepted_writes++;
    read_check("wr_rd_addr10", 6'd10, 64'hA5A5_A5A5_A5A5_A5A5);
    check_value("wr_count_after_one", {48'h0, mif.wr_count}, exp_count());

    // Core write over a loaded word. The memory must not fight the core.
    mif.d_mem_we = 1'b1; mif.d_mem_addr = 6'd5;
    core_drive = 1'b1; core_data = 64'h5555_0000_AAAA_1234;
    sb_bus("wr_bus_over_loaded", 64'h5555_0000_AAAA_1234);
    step();
    accepted_writes++;
    read_check("wr_rd_addr5", 6'd5, 64'h5555_0000_AAAA_1234);
    check_value("wr_count_after_two", {48'h0, mif.wr_count}, exp_count());

    // Collision: the loader and the core both write address 3.
    mif.ld_en = 1'b1; mif.ld_addr = 6'd3; mif.ld_data = 64'h1111;
    mif.d_mem_we = 1'b1; mif.d_mem_addr = 6'd3;
    core_drive = 1'b1; core_data = 64'h2222;
    step();
    idle_bus();
    check_value("col_conflict", {63'h0, mif.conflict}, 64'h1);
    check_value("col_wr_count", {48'h0, mif.wr_count}, exp_count());
    read_check("col_rd_addr3", 6'd3, 64'h1111);
    repeat (10) step();
    check_value("col_conflict_sticky", {63'h0, mif.conflict}, 64'h1);
    check_value("col_wr_count_idle", {48'h0, mif.wr_count}, exp_count());

    // Set up a mid-operation reset: write 0x42 to address 2 and put stale data at 63.
    mif.d_mem_we = 1'b1; mif.d_mem_addr = 6'd2;
    core_drive = 1'b1; core_data = 64'h42;
    step();
    accepted_writes++;
    mif.d_mem_we = 1'b0; core_drive = 1'b0;
    mif.ld_en = 1'b1; mif.ld_addr = 6'd63; mif.ld_data = 64'h6363_6363_6363_6363;
    step();
    mif.ld_en = 1'b0;
    read_check("pre_rst_rd_addr2", 6'd2, 64'h42);
    read_check("pre_rst_rd_addr63", 6'd63, 64'h6363_6363_6363_6363);
    check_value("pre_rst_wr_count", {48'h0, mif.wr_count}, exp_count());

    // One-edge reset pulse.
    rst_n = 1'b0;
    step();
    accepted_writes = 0;
    check_value("pulse_ready", {63'h0, mif.ready}, 64'h0);
    check_value("pulse_conflict", {63'h0, mif.conflict}, 64'h0);
    check_value("pulse_wr_count", {48'h0, mif.wr_count}, 64'h0);
    run_init(1'b0, 64'h6363_6363_6363_6363);
    read_check("post_rst_rd_addr2", 6'd2, 64'h0);
    read_check("post_rst_rd_addr63", 6'd63, 64'h0);

    if (sb_q.size() != 0) check_value("sb_leftover", 64'(sb_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/d_mem_responder.md
Name: d_mem_responder

Overview:
- Memory-side responder for the processor's data-memory port: the end that answers `d_mem_we`, `d_mem_addr` and the shared bidirectional `d_mem_data` bus.
- Holds 2^d_addr_bits 64-bit words.
- Writes are registered. Reads are combinational, as the single-cycle datapath requires.
- After reset, an init FSM clears the array. A side loader port lets the bench preload data.
- Sits at top level next to the core and is wired directly to the core's d_mem pins.

Parameters:
- d_addr_bits, 6, word-address width; depth = 2^d_addr_bits 64-bit words.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous reset, active low
- d_mem_we  input  1  write enable from core; 1 = core drives bus, memory writes
- d_mem_addr  input  d_addr_bits  word index (not byte address)
- d_mem_data  inout  64  shared data bus; memory drives only during reads
- ld_en  input  1  loader write strobe
- ld_addr  input  d_addr_bits  loader word index
- ld_data  input  64  loader write data
- ready  output  1  1 = init clear finished, memory serving accesses
- conflict  output  1  sticky; set when loader and core write in the same cycle
- wr_count  output  16  core write counter (see Optional Feature)

Behaviour:
- Reset (rst_n = 0 at a rising edge):
  - state ← INIT, clear counter ← 0.
  - ready = 0, conflict = 0, wr_count = 0.
  - Array contents are not touched while rst_n stays low.
  - Applies from any state, including mid-clear or mid-write. No write is performed on a reset edge.
- INIT state:
  - Each edge with rst_n = 1 writes 0 to mem[clr_cnt] and increments clr_cnt.
  - The edge that clears the last word (clr_cnt = 2^d_addr_bits − 1) moves state to READY and sets ready = 1.
  - Default config: ready rises after the 64th edge following reset release.
  - During INIT, d_mem_data is high-Z, d_mem_we is ignored and ld_en is ignored. Writes in INIT are dropped and not counted.
- READY state:
  - Stays in READY until reset.
  - Bus drive: d_mem_data = mem[d_mem_addr] when d_mem_we = 0, else high-Z. This is combinational, with no cycle latency.
  - Core write: if d_mem_we = 1 and ld_en = 0, mem[d_mem_addr] ← d_mem_data at the edge.
  - Loader write: if ld_en = 1, mem[ld_addr] ← ld_data at the edge.
  - Simultaneous ld_en = 1 and d_mem_we = 1 (any addresses):
    - Loader write wins; the core write is dropped.
    - conflict ← 1 and stays set until reset.
    - wr_count does not increment.
  - A read of the same address on the cycle after a write returns the new data. A read during the write cycle is impossible, because the bus is owned by the core.
- Address range: full range is valid, with no wrap logic needed; the index width equals the array index width.
- X/Z on d_mem_data during a core write is stored as-is; no checking.

Optional Feature:
- Macro: D_MEM_WR_COUNT_EN.
- Defined:
  - wr_count increments by 1 on every accepted core write (READY, d_mem_we = 1, ld_en = 0).
  - Saturates at 16'hFFFF.
  - Reset to 0.
  - Loader writes are not counted.
- Not defined:
  - wr_count is tied to 16'h0000 and no counter register is synthesised.
  - All other behaviour is identical.

Test Plan:
- Reset and init: hold rst_n = 0 for 3 edges, then release → ready = 0 for 63 edges and 1 after the 64th. Then read addr 0, 31 and 63 with we = 0 → d_mem_data = 64'h0 each.
- Loader and read: in READY, ld_en = 1, ld_addr = 5, ld_data = 64'hDEAD_BEEF_0123_4567 for one edge. Then d_mem_addr = 5, we = 0 → same cycle d_mem_data = 64'hDEAD_BEEF_0123_4567.
- Core write and bus turnaround:
  - Core drives 64'hA5A5_A5A5_A5A5_A5A5 with we = 1, addr = 10 → memory output is Z during that cycle.
  - Next cycle with we = 0, addr = 10 → reads 64'hA5A5_A5A5_A5A5_A5A5.
  - wr_count = 1 with D_MEM_WR_COUNT_EN, 0 without.
- Collision: same edge, ld_en = 1, ld_addr = 3, ld_data = 64'h1111 and core we = 1, addr = 3, data = 64'h2222 → mem[3] = 64'h1111, conflict = 1 and remains 1 over 10 further idle edges, wr_count unchanged.
- Writes during INIT: drive we = 1, addr = 7, data = 64'hFF and ld_en = 1 during the clear phase → after ready = 1, mem[7] reads 64'h0 and wr_count = 0.
- Reset mid-operation: after writing 64'h42 to addr 2 in READY, pulse rst_n = 0 for 1 edge → ready drops next edge, conflict and wr_count become 0, the clear reruns over 64 edges, then addr 2 reads 64'h0.
